// File: rtl/frame_source_ctrl.sv
// frame_source_ctrl: turns a start command into N frames of L words read from a 1-cycle-latency source,
// presented on a valid/ready stream through a 2-entry skid FIFO with per-word last tags.
module frame_source_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16,
   parameter int CNT_WIDTH  = 16,
   parameter int GAP_WIDTH  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [LEN_WIDTH-1:0]  i_frame_len,
   input  logic [CNT_WIDTH-1:0]  i_frame_count,
   input  logic [GAP_WIDTH-1:0]  i_gap,
   input  logic                  i_abort,
   output logic                  o_src_enable,
   input  logic [DATA_WIDTH-1:0] i_src_data,
   input  logic                  i_src_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_last,
   output logic                  o_busy,
   output logic                  o_done
);
   typedef enum logic [2:0] {IDLE, RUN, GAP, DRAIN, DONE} state_t;
   state_t                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d, word_q, word_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, frame_q, frame_d;
   logic [GAP_WIDTH-1:0]  gap_q, gap_d, gcnt_q, gcnt_d;
   logic                  infl_q, infl_d, infl_last_q, infl_last_d;
   logic [DATA_WIDTH:0]   mem_q [2];
   logic                  rd_q, rd_d, wr_q, wr_d;
   logic [1:0]            occ_q, occ_d;
   logic                  pop, push, kill, word_last, frame_last;
   logic [2:0]            room;

   assign o_valid = occ_q != 2'd0;
   assign o_data  = o_valid ? mem_q[rd_q][DATA_WIDTH-1:0] : '0;
   assign o_last  = o_valid & mem_q[rd_q][DATA_WIDTH];
   assign o_busy  = state_q != IDLE;
   assign o_done  = state_q == DONE;

   always_comb begin
      pop          = o_valid & i_ready;
      push         = infl_q & i_src_valid;
      kill         = i_abort && (state_q != IDLE);
      // the in-flight word already owns a FIFO slot, so it counts against the 2-entry limit
      room         = 3'(occ_q) + 3'(infl_q) - 3'(pop);
      o_src_enable = (state_q == RUN) && (room < 3'd2) && !i_abort;
      word_last    = word_q == len_q - LEN_WIDTH'(1);
      frame_last   = frame_q == cnt_q - CNT_WIDTH'(1);
      occ_d        = occ_q + 2'(push) - 2'(pop);
      rd_d         = kill ? 1'b0 : rd_q ^ pop;
      wr_d         = kill ? 1'b0 : wr_q ^ push;
      infl_d       = o_src_enable;
      infl_last_d  = word_last;
      state_d      = state_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      gap_d        = gap_q;
      word_d       = word_q;
      frame_d      = frame_q;
      gcnt_d       = gcnt_q;
      case (state_q)
         IDLE: if (i_start && !i_abort) begin
            len_d   = i_frame_len;
            cnt_d   = i_frame_count;
            gap_d   = i_gap;
            word_d  = '0;
            frame_d = '0;
            state_d = (i_frame_len == '0 || i_frame_count == '0) ? DONE : RUN;
         end
         RUN: if (o_src_enable) begin
            word_d = word_last ? '0 : word_q + LEN_WIDTH'(1);
            if (word_last) begin
               frame_d = frame_q + CNT_WIDTH'(1);
               gcnt_d  = '0;
               state_d = frame_last ? DRAIN : (gap_q != '0 ? GAP : RUN);
            end
         end
         GAP: begin
            gcnt_d  = gcnt_q + GAP_WIDTH'(1);
            state_d = (gcnt_q == gap_q - GAP_WIDTH'(1)) ? RUN : GAP;
         end
         DRAIN: state_d = (occ_d == 2'd0) ? DONE : DRAIN;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (kill) begin
         state_d = IDLE;
         occ_d   = 2'd0;
         infl_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
         word_q      <= '0;
         frame_q     <= '0;
         gcnt_q      <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         occ_q       <= 2'd0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         word_q      <= word_d;
         frame_q     <= frame_d;
         gcnt_q      <= gcnt_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         occ_q       <= occ_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         if (push && !kill) mem_q[wr_q] <= {infl_last_q, i_src_data};
      end
   end
endmodule

// File: tb/tb_frame_source_ctrl.sv
// tb_frame_source_ctrl: directed runs against a word-list model of the expected stream plus literal timing pins.
module tb_frame_source_ctrl;
   logic        clk = 1'b0;
   logic        rst, start, abort, ready, src_valid, en, valid, last, busy, done;
   logic [15:0] flen, fcnt;
   logic [7:0]  gap, src_data, data, addr;
   int          total = 0, bad = 0, cyc = 0, t0 = 0, done_at = -1, outst = 0;
   bit          run_on = 0, chk_on = 0;
   logic [8:0]  exp_q [$];
   logic [3:0]  pat = 4'b1001;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // memory-backed source: word value is its address within the run, returned one cycle after enable
   always @(posedge clk) begin
      src_valid <= en;
      src_data  <= addr;
      addr      <= busy ? addr + 8'(en) : 8'd0;
   end

   frame_source_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_frame_len(flen), .i_frame_count(fcnt),
      .i_gap(gap), .i_abort(abort), .o_src_enable(en), .i_src_data(src_data), .i_src_valid(src_valid),
      .o_data(data), .o_valid(valid), .i_ready(ready), .o_last(last), .o_busy(busy), .o_done(done)
   );

   task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc - t0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int l, input int c, input int g);
      flen = 16'(l);
      fcnt = 16'(c);
      gap  = 8'(g);
      for (int f = 0; f < c && l > 0; f++)
         for (int w = 0; w < l; w++) exp_q.push_back({w == l - 1, 8'(f * l + w)});
      run_on  = (l != 0 && c != 0);
      done_at = run_on ? -1 : cyc + 1;
      t0      = cyc;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (busy && n < lim) begin
         tick();
         n++;
      end
      check("finish_in_time", busy, 0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   task automatic flush_model();
      exp_q.delete();
      run_on  = 0;
      done_at = -1;
   endtask

   initial begin
      logic pv = 0, pr = 0, pl = 0, pk = 1;
      logic [7:0] pd = 0;
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            check("done", done, cyc == done_at);
            if (valid) check("busy_with_valid", busy, 1);
            if (pv && !pr && !pk) begin
               check("hold_valid", valid, 1);
               check("hold_data", data, pd);
               check("hold_last", last, pl);
            end
            if (valid && ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_word: got %0h expected no word", {last, data});
               end else begin
                  e = exp_q.pop_front();
                  check("word", {last, data}, e);
                  if (exp_q.size() == 0 && run_on) begin
                     done_at = cyc + 1;
                     run_on  = 0;
                  end
               end
            end
            outst += int'(en) - int'(valid && ready);
            if (en) check("no_overflow", outst <= 2, 1);
            pk = rst || (abort && busy);
            if (pk) outst = 0;
         end
         pv = valid; pr = ready; pd = data; pl = last;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1; start = 0; abort = 0; ready = 1; flen = 0; fcnt = 0; gap = 0;
      repeat (2) tick();
      check("reset_outputs", {en, valid, last, busy, done, data}, 0);
      rst = 0;
      chk_on = 1;
      tick();
      // 1: two back-to-back frames of 4
      start_run(4, 2, 0);
      for (int k = 1; k <= 12; k++) begin
         if (k <= 8) check("t1_enable", en, 1);
         check("t1_valid", valid, k >= 3 && k <= 10);
         if (valid) check("t1_data", data, k - 3);
         check("t1_last", last, k == 6 || k == 10);
         check("t1_done", done, k == 11);
         tick();
      end
      check("t1_idle", busy, 0);
      // 2: gap of 3 idle output cycles between frames
      start_run(3, 2, 3);
      for (int k = 1; k <= 13; k++) begin
         check("t2_valid", valid, (k >= 3 && k <= 5) || (k >= 9 && k <= 11));
         check("t2_done", done, k == 12);
         tick();
      end
      // 3: backpressure pattern 1,0,0,1
      start_run(16, 1, 0);
      for (int n = 0; busy && n < 200; n++) begin
         ready = pat[n % 4];
         tick();
      end
      ready = 1;
      wait_idle(10);
      // 4: abort on the 5th handshake, then a fresh run
      start_run(8, 4, 0);
      repeat (6) tick();
      abort = 1;
      check("t4_valid_at_abort", valid, 1);
      check("t4_data_at_abort", data, 8'h04);
      tick();
      abort = 0;
      flush_model();
      check("t4_valid_after", valid, 0);
      check("t4_busy_after", busy, 0);
      repeat (3) tick();
      start_run(2, 2, 0);
      wait_idle(50);
      // 5: empty run completes immediately; start during RUN ignored
      start_run(0, 5, 0);
      check("t5_no_enable", en, 0);
      check("t5_done", done, 1);
      tick();
      check("t5_idle", {busy, done}, 0);
      start_run(4, 2, 0);
      repeat (3) tick();
      start = 1; flen = 1; fcnt = 1;
      tick();
      start = 0;
      wait_idle(50);
      // 6: reset mid-frame, late source word must be dropped
      start_run(8, 1, 0);
      repeat (4) tick();
      rst = 1;
      tick();
      rst = 0;
      flush_model();
      check("t6_outputs", {en, valid, last, busy, done, data}, 0);
      tick();
      check("t6_late_word", valid, 0);
      tick();
      start_run(2, 1, 0);
      wait_idle(50);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
